alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU.
- Keeps the full arithmetic, logic and compare set and registers the result.
- Adds shift ops and an iterative shift-add multiplier; an optional iterative unsigned divider is compiled in by macro.
- Sits between decode/issue and writeback: valid/ready on both sides, one operation in flight.

Parameters:
- WIDTH, 32: operand/result width in bits (even, >=8).
- FUNC_BITS, 5: func code width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- func  in  FUNC_BITS  operation code.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- err  out  1  result flag: illegal func or divide-by-zero.
- busy  out  1  iterative op in progress.

Behaviour:
- Func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR.
  - 8 MVHI: in2 << (WIDTH/2).
  - 9 SHL, 10 SHR (logical), 11 SRA. Shift amount = in2[$clog2(WIDTH)-1:0].
  - 12 MUL, 13 DIVU, 14 REMU.
  - 16 F, 17 EQ, 18 LT, 19 LTE, 20 T, 21 NE, 22 GTE, 23 GT. LT/LTE/GTE/GT are signed; compare results are 0 or 1, zero-extended.
  - Any other code: result 0, err=1.
- Arithmetic is modulo 2^WIDTH; MUL returns the low WIDTH bits of the product.
- Transfers: input accepted on clk edge with in_valid && in_ready; output consumed on clk edge with out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1. Accepting a single-cycle op goes to DONE with result registered. Accepting MUL/DIVU/REMU goes to BUSY.
  - BUSY: busy=1, in_ready=0, one iteration per cycle for exactly WIDTH cycles, then DONE.
  - DONE: out_valid=1; result/err held stable until consumed. in_ready = out_ready. Consume plus new accept in the same cycle follows the same next-state rules as IDLE (single-cycle op -> DONE, iterative -> BUSY). Consume without accept -> IDLE.
- Latency:
  - Single-cycle ops: accept at edge N, out_valid high after edge N+1. Throughput 1 op/cycle when out_ready is held high.
  - Iterative ops: out_valid high after edge N+WIDTH+1.
- Operands and func are captured at accept. Later changes to in1/in2/func do not affect the op in flight.
- in_valid while in_ready=0 is ignored; no accept occurs.
- Reset values: out_valid=0, result=0, err=0, busy=0, state=IDLE. in_ready=1 combinationally while in reset and after.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately. The partial result is discarded and never presented.
- MUL with either operand 0 still takes WIDTH cycles; there is no early termination.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: DIVU/REMU use a restoring divider, WIDTH iterations in BUSY, unsigned operands.
  - in2=0: DIVU result all ones, REMU result = in1, err=1.
  - Timing unchanged for divide-by-zero.
- Undefined: codes 13/14 are illegal, single-cycle: result 0, err=1, DONE after 1 cycle. No divider logic is synthesised.

Test Plan:
- Reset then idle, out_ready=1 -> in_ready=1, out_valid=0, result=0, err=0, busy=0.
- Back-to-back single-cycle ops, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> 0, err=0.
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - MVHI in2=0x1234 -> 0x12340000.
  - LT -1 vs 1 -> 1.
  - One result per cycle, each one cycle after its accept.
- MUL 0x10000 x 0x10003 -> result 0x00030000 after 33 cycles, busy=1 for 32 cycles, in_ready=0 throughout BUSY.
- Backpressure: out_ready=0 for 5 cycles after an ADD 7+8 result -> result holds 15, out_valid=1, in_ready=0; the second op is accepted only on the cycle out_ready rises.
- With ALU_SEQ_DIV_EN: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, err=1. Without the macro: func 13 -> result 0, err=1, latency 1.
- Assert reset_n low at cycle 10 of a MUL -> out_valid=0, busy=0 immediately; after release, ADD 1+1 -> 2 with normal latency. func 31 -> result 0, err=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered single-cycle ops plus an iterative shift-add multiplier.
// Optional macro ALU_SEQ_DIV_EN adds an iterative restoring DIVU/REMU; otherwise codes 13/14 are illegal.
module alu_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FUNC_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [FUNC_BITS-1:0] func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned HALF  = WIDTH / 2;

  localparam logic [FUNC_BITS-1:0] F_ADD  = FUNC_BITS'(0);
  localparam logic [FUNC_BITS-1:0] F_SUB  = FUNC_BITS'(1);
  localparam logic [FUNC_BITS-1:0] F_AND  = FUNC_BITS'(2);
  localparam logic [FUNC_BITS-1:0] F_OR   = FUNC_BITS'(3);
  localparam logic [FUNC_BITS-1:0] F_XOR  = FUNC_BITS'(4);
  localparam logic [FUNC_BITS-1:0] F_NAND = FUNC_BITS'(5);
  localparam logic [FUNC_BITS-1:0] F_NOR  = FUNC_BITS'(6);
  localparam logic [FUNC_BITS-1:0] F_XNOR = FUNC_BITS'(7);
  localparam logic [FUNC_BITS-1:0] F_MVHI = FUNC_BITS'(8);
  localparam logic [FUNC_BITS-1:0] F_SHL  = FUNC_BITS'(9);
  localparam logic [FUNC_BITS-1:0] F_SHR  = FUNC_BITS'(10);
  localparam logic [FUNC_BITS-1:0] F_SRA  = FUNC_BITS'(11);
  localparam logic [FUNC_BITS-1:0] F_MUL  = FUNC_BITS'(12);
`ifdef ALU_SEQ_DIV_EN
  localparam logic [FUNC_BITS-1:0] F_DIVU = FUNC_BITS'(13);
  localparam logic [FUNC_BITS-1:0] F_REMU = FUNC_BITS'(14);
`endif
  localparam logic [FUNC_BITS-1:0] F_F    = FUNC_BITS'(16);
  localparam logic [FUNC_BITS-1:0] F_EQ   = FUNC_BITS'(17);
  localparam logic [FUNC_BITS-1:0] F_LT   = FUNC_BITS'(18);
  localparam logic [FUNC_BITS-1:0] F_LTE  = FUNC_BITS'(19);
  localparam logic [FUNC_BITS-1:0] F_T    = FUNC_BITS'(20);
  localparam logic [FUNC_BITS-1:0] F_NE   = FUNC_BITS'(21);
  localparam logic [FUNC_BITS-1:0] F_GTE  = FUNC_BITS'(22);
  localparam logic [FUNC_BITS-1:0] F_GT   = FUNC_BITS'(23);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   accept;
  logic                   is_iter;
  logic                   iter_err;
  logic [SH_W-1:0]        shamt;
  logic                   lt_s, eq;
  logic [WIDTH-1:0]       sc_res;
  logic                   sc_err;

  logic [FUNC_BITS-1:0]   op_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0]       a_q, b_q, acc_q;
  logic [WIDTH-1:0]       a_nx, b_nx, acc_nx;
  logic [WIDTH-1:0]       fin_res;
  logic [WIDTH-1:0]       result_q;
  logic                   err_q;

  assign accept = in_valid && in_ready;
  assign shamt  = in2[SH_W-1:0];
  assign result = result_q;
  assign err    = err_q;

  // Operations that run through the BUSY iteration loop
  always_comb begin : iter_decode
    is_iter = (func == F_MUL);
`ifdef ALU_SEQ_DIV_EN
    if ((func == F_DIVU) || (func == F_REMU)) begin
      is_iter = 1'b1;
    end
`endif
  end

  // Single-cycle result and illegal-code detection
  always_comb begin : single_cycle
    sc_res = '0;
    sc_err = 1'b0;
    lt_s   = $signed(in1) < $signed(in2);
    eq     = (in1 == in2);
    case (func)
      F_ADD:  sc_res = in1 + in2;
      F_SUB:  sc_res = in1 - in2;
      F_AND:  sc_res = in1 & in2;
      F_OR:   sc_res = in1 | in2;
      F_XOR:  sc_res = in1 ^ in2;
      F_NAND: sc_res = ~(in1 & in2);
      F_NOR:  sc_res = ~(in1 | in2);
      F_XNOR: sc_res = ~(in1 ^ in2);
      F_MVHI: sc_res = in2 << HALF;
      F_SHL:  sc_res = in1 << shamt;
      F_SHR:  sc_res = in1 >> shamt;
      F_SRA:  sc_res = $signed(in1) >>> shamt;
      F_MUL:  sc_res = '0;
`ifdef ALU_SEQ_DIV_EN
      F_DIVU: sc_res = '0;
      F_REMU: sc_res = '0;
`endif
      F_F:    sc_res = '0;
      F_EQ:   sc_res = WIDTH'(eq);
      F_LT:   sc_res = WIDTH'(lt_s);
      F_LTE:  sc_res = WIDTH'(lt_s || eq);
      F_T:    sc_res = WIDTH'(1'b1);
      F_NE:   sc_res = WIDTH'(!eq);
      F_GTE:  sc_res = WIDTH'(!lt_s);
      F_GT:   sc_res = WIDTH'(!(lt_s || eq));
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;
  logic           dz_q;
`endif

  // One iteration step: shift-add multiply, or one restoring-divide bit
  always_comb begin : iterate
    a_nx    = a_q;
    b_nx    = b_q;
    acc_nx  = acc_q;
    fin_res = '0;
`ifdef ALU_SEQ_DIV_EN
    rem_sh   = '0;
    rem_diff = '0;
`endif
    if (op_q == F_MUL) begin
      acc_nx  = b_q[0] ? (acc_q + a_q) : acc_q;
      a_nx    = a_q << 1;
      b_nx    = b_q >> 1;
      fin_res = acc_nx;
    end
`ifdef ALU_SEQ_DIV_EN
    else begin
      // a_q shifts dividend bits out and quotient bits in; acc_q is the partial remainder
      rem_sh   = {acc_q, a_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      if (rem_sh >= {1'b0, b_q}) begin
        acc_nx = rem_diff[WIDTH-1:0];
        a_nx   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        a_nx   = {a_q[WIDTH-2:0], 1'b0};
      end
      fin_res = (op_q == F_REMU) ? acc_nx : a_nx;
    end
`endif
  end

`ifdef ALU_SEQ_DIV_EN
  assign iter_err = dz_q && (op_q != F_MUL);

  always_ff @(posedge clk or negedge reset_n) begin : dz_reg
    if (!reset_n) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= (in2 == '0);
    end
  end
`else
  assign iter_err = 1'b0;
`endif

  // Operand capture, iteration registers and the held result
  always_ff @(posedge clk or negedge reset_n) begin : datapath
    if (!reset_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q  <= func;
      cnt_q <= CNT_W'(WIDTH - 1);
      a_q   <= in1;
      b_q   <= in2;
      acc_q <= '0;
      if (!is_iter) begin
        result_q <= sc_res;
        err_q    <= sc_err;
      end
    end else if (state_q == S_BUSY) begin
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        result_q <= fin_res;
        err_q    <= iter_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = is_iter ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_d = is_iter ? S_BUSY : S_DONE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand sequences for multi-cycle corners,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned FB = 5;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1, in2;
  logic [FB-1:0] func;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W), .FUNC_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [FB-1:0] f;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  res;
    logic          e;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions; lat is cycles from accept edge to out_valid
  function automatic void model(input logic [FB-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e, output int lat);
    logic [2*W-1:0] prod;
    r = '0; e = 1'b0; lat = 1;
    case (f)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = ~(a & b);
      5'd6:  r = ~(a | b);
      5'd7:  r = ~(a ^ b);
      5'd8:  r = b << (W / 2);
      5'd9:  r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: r = $signed(a) >>> b[4:0];
      5'd12: begin prod = 64'(a) * 64'(b); r = prod[W-1:0]; lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      5'd13: begin lat = W + 1; if (b == 0) begin r = '1; e = 1'b1; end else r = a / b; end
      5'd14: begin lat = W + 1; if (b == 0) begin r = a;  e = 1'b1; end else r = a % b; end
`endif
      5'd16: r = '0;
      5'd17: r = W'(a == b);
      5'd18: r = W'($signed(a) <  $signed(b));
      5'd19: r = W'($signed(a) <= $signed(b));
      5'd20: r = W'(1);
      5'd21: r = W'(a != b);
      5'd22: r = W'($signed(a) >= $signed(b));
      5'd23: r = W'($signed(a) >  $signed(b));
      default: e = 1'b1;
    endcase
  endfunction

  // Offer one op, wait for its result, optionally stall the consumer, then consume it
  task automatic run_op(input string name, input logic [FB-1:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ee,
                        input int el, input int stall);
    int n;
    int lat;
    in1 = a; in2 = b; func = f; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({name, " accept"}, 64'(n < 100), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; func = FB'($urandom);
    out_ready = (stall == 0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({name, " latency"}, 64'(lat), 64'(el));
    check({name, " result"}, 64'(result), 64'(er));
    check({name, " err"}, 64'(err), 64'(ee));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({name, " held"}, {31'd0, out_valid, result}, {31'd0, 1'b1, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " consumed"}, 64'(out_valid), 64'(0));
  endtask

  vec_t vecs[$];
  logic [W-1:0] er;
  logic ee;
  int el;
  int cnt;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; func = '0;

    vecs.push_back('{5'd0,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd1,  32'd3,         32'd5,          32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{5'd11, 32'h8000_0000, 32'd4,          32'hF800_0000, 1'b0, 1});
    vecs.push_back('{5'd8,  32'h0,         32'h1234,       32'h1234_0000, 1'b0, 1});
    vecs.push_back('{5'd18, 32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1});
    vecs.push_back('{5'd10, 32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0, 1});
    vecs.push_back('{5'd9,  32'd1,         32'd63,         32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FFF_0FFF, 1'b0, 1});
    vecs.push_back('{5'd7,  32'h1234_5678, 32'h1234_5678,  32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{5'd23, 32'd1,         32'hFFFF_FFFF,  32'd1,         1'b0, 1});
    vecs.push_back('{5'd19, 32'd7,         32'd7,          32'd1,         1'b0, 1});
    vecs.push_back('{5'd20, 32'd0,         32'd0,          32'd1,         1'b0, 1});
    vecs.push_back('{5'd12, 32'h0001_0000, 32'h0001_0003,  32'h0003_0000, 1'b0, 33});
    vecs.push_back('{5'd12, 32'd0,         32'hFFFF_FFFF,  32'd0,         1'b0, 33});
    vecs.push_back('{5'd31, 32'd9,         32'd9,          32'd0,         1'b1, 1});
    vecs.push_back('{5'd15, 32'd9,         32'd9,          32'd0,         1'b1, 1});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{5'd13, 32'd100,       32'd7,          32'd14,        1'b0, 33});
    vecs.push_back('{5'd14, 32'd100,       32'd7,          32'd2,         1'b0, 33});
    vecs.push_back('{5'd13, 32'd5,         32'd0,          32'hFFFF_FFFF, 1'b1, 33});
    vecs.push_back('{5'd14, 32'd5,         32'd0,          32'd5,         1'b1, 33});
`else
    vecs.push_back('{5'd13, 32'd100,       32'd7,          32'd0,         1'b1, 1});
    vecs.push_back('{5'd14, 32'd100,       32'd7,          32'd0,         1'b1, 1});
`endif

    // Reset state, both during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {in_ready, out_valid, err, busy, result}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle outputs", {in_ready, out_valid, err, busy, result}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].e,
             vecs[i].lat, 0);

    // Back-to-back single-cycle ops: one result per cycle, each one cycle after its accept
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in1 = vecs[i].a; in2 = vecs[i].b; func = vecs[i].f; in_valid = 1'b1;
      check($sformatf("b2b%0d ready", i), 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      check($sformatf("b2b%0d out", i), {31'd0, out_valid, result}, {31'd0, 1'b1, vecs[i].res});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b drained", 64'(out_valid), 64'(0));

    // MUL: WIDTH busy cycles with in_ready low; an op offered meanwhile is taken on consume
    in1 = 32'h0001_0000; in2 = 32'h0001_0003; func = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 32'd2; in2 = 32'd3; func = 5'd0;
    cnt = 0;
    while (busy && cnt < 100) begin
      if (in_ready) check("mul in_ready during busy", 64'(in_ready), 64'(0));
      cnt++;
      @(posedge clk); #1;
    end
    check("mul busy cycles", 64'(cnt), 64'(W));
    check("mul result", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h0003_0000});
    @(posedge clk); #1;
    check("add after mul", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd5});
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: result holds for 5 cycles, second op taken when out_ready rises
    in1 = 32'd7; in2 = 32'd8; func = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in1 = 32'd10; in2 = 32'd4; func = 5'd1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp hold%0d", s), {30'd0, out_valid, in_ready, result},
            {30'd0, 1'b1, 1'b0, 32'd15});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp ready follows out_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second op", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd6});
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'(0));

    // Reset in the middle of a MUL aborts it; the partial result never shows up
    in1 = 32'hFFFF; in2 = 32'hFFFF; func = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid-mul busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("abort outputs", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt = 0;
    for (int s = 0; s < 40; s++) begin
      @(posedge clk); #1;
      if (out_valid || busy) cnt++;
    end
    check("no stale result", 64'(cnt), 64'(0));
    run_op("add after reset", 5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);
    run_op("func31", 5'd31, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0);

    // Randomized ops with random consumer stalls
    for (int i = 0; i < 150; i++) begin
      logic [FB-1:0] f;
      logic [W-1:0]  a, b;
      f = FB'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(0, 40));
        3:       b = a;
        default: b = W'($urandom);
      endcase
      model(f, a, b, er, ee, el);
      run_op($sformatf("rand%0d f%0d", i, f), f, a, b, er, ee, el, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
